reg_file: RTL and testbench



---
 rtl/reg_file.sv | 45 ++++
 tb/tb_reg_file.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/reg_file.sv
// 32 x DATA_W general-purpose register file: two combinational read ports, one synchronous write port.
// Optional write-to-read forwarding is enabled by defining REGFILE_BYPASS_EN.
module reg_file #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] A1,
    input  logic [ADDR_W-1:0] A2,
    input  logic [ADDR_W-1:0] WriteReg,
    input  logic [DATA_W-1:0] WD,
    input  logic              RorW,
    output logic [DATA_W-1:0] RD1,
    output logic [DATA_W-1:0] RD2
);

    localparam int unsigned NREG = 2 ** ADDR_W;

    logic [DATA_W-1:0] regs [0:NREG-1];
    logic              wr_en;

    assign wr_en = RorW && (WriteReg != '0);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < NREG; i++) begin
                regs[i[ADDR_W-1:0]] <= '0;
            end
        end else if (wr_en) begin
            regs[WriteReg] <= WD;
        end
    end

    // r0 is forced to zero on the read side, so its storage never matters.
    always_comb begin
        RD1 = (A1 == '0) ? '0 : regs[A1];
        RD2 = (A2 == '0) ? '0 : regs[A2];
`ifdef REGFILE_BYPASS_EN
        if (rst_n && wr_en && (A1 == WriteReg)) RD1 = WD;
        if (rst_n && wr_en && (A2 == WriteReg)) RD2 = WD;
`endif
    end

endmodule

// File: tb/tb_reg_file.sv
// Scoreboard bench for reg_file: stimulus queues expected RD1/RD2 values,
// a monitor compares them against the DUT on the falling clock edge.
module tb_reg_file;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [4:0]  A1, A2, WriteReg;
    logic [31:0] WD;
    logic        RorW;
    logic [31:0] RD1, RD2;

    typedef struct {
        string       name;
        logic [31:0] e1;
        logic [31:0] e2;
    } exp_t;

    exp_t exp_q[$];
    int   compared   = 0;
    int   mismatched = 0;

    reg_file #(.DATA_W(32), .ADDR_W(5)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .A1       (A1),
        .A2       (A2),
        .WriteReg (WriteReg),
        .WD       (WD),
        .RorW     (RorW),
        .RD1      (RD1),
        .RD2      (RD2)
    );

    always #5 clk = ~clk;

    // Monitor: one expectation per cycle, checked mid-cycle.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            compared++;
            if (RD1 !== e.e1 || RD2 !== e.e2) begin
                mismatched++;
                $display("FAIL %s: RD1=%h RD2=%h expected RD1=%h RD2=%h",
                         e.name, RD1, RD2, e.e1, e.e2);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_rd(input string name, input logic [31:0] e1, input logic [31:0] e2);
        exp_t e;
        e.name = name;
        e.e1   = e1;
        e.e2   = e2;
        exp_q.push_back(e);
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] d);
        RorW = 1'b1; WriteReg = a; WD = d;
        step();
        RorW = 1'b0;
    endtask

    function automatic logic [31:0] pat(input int unsigned i);
        return (i == 0) ? 32'h0 : 32'hC0DE_0000 + i * 32'd257;
    endfunction

    initial begin
        logic [31:0] same_cycle_exp;
        int unsigned a2;

        rst_n = 1'b1; RorW = 1'b0; A1 = '0; A2 = '0; WriteReg = '0; WD = '0;
        #1;
        // Arbitrary contents before reset
        wr(5'd3, 32'h1111_2222);
        wr(5'd7, 32'h3333_4444);
        wr(5'd31, 32'hFFFF_0000);

        // Reset: everything clears, swept across all addresses
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 32; i++) begin
            A1 = 5'(i); A2 = 5'(31 - i);
            expect_rd("reset_sweep", 32'h0, 32'h0);
            step();
        end

        // Basic write/read
        wr(5'd10, 32'd256);
        wr(5'd11, 32'd65535);
        A1 = 5'd10; A2 = 5'd11;
        for (int i = 0; i < 3; i++) begin
            expect_rd("basic_rw", 32'd256, 32'd65535);
            step();
        end

        // Write disable: RorW=0 must not modify r10
        RorW = 1'b0; WriteReg = 5'd10; WD = 32'hDEAD_BEEF;
        for (int i = 0; i < 3; i++) begin
            expect_rd("write_disable", 32'd256, 32'd65535);
            step();
        end

        // r0 protection, before and after the write edge
        A1 = 5'd0; A2 = 5'd0;
        RorW = 1'b1; WriteReg = 5'd0; WD = 32'hFFFF_FFFF;
        expect_rd("r0_same_cycle", 32'h0, 32'h0);
        step();
        RorW = 1'b0;
        expect_rd("r0_after", 32'h0, 32'h0);
        step();

        // Reset priority over a simultaneous write
        wr(5'd5, 32'd99);
        A1 = 5'd5; A2 = 5'd10;
        expect_rd("pre_reset_r5", 32'd99, 32'd256);
        step();
        rst_n = 1'b0; RorW = 1'b1; WriteReg = 5'd5; WD = 32'd7;
        step();
        rst_n = 1'b1; RorW = 1'b0;
        expect_rd("reset_priority", 32'h0, 32'h0);
        step();

        // Same-cycle read of the write target
`ifdef REGFILE_BYPASS_EN
        same_cycle_exp = 32'h1234;
`else
        same_cycle_exp = 32'h0;
`endif
        A1 = 5'd12; A2 = 5'd12;
        RorW = 1'b1; WriteReg = 5'd12; WD = 32'h1234;
        expect_rd("same_cycle_before", same_cycle_exp, same_cycle_exp);
        step();
        RorW = 1'b0;
        expect_rd("same_cycle_after", 32'h1234, 32'h1234);
        step();

        // Distinct pattern in every register, read back through both ports
        for (int unsigned i = 1; i < 32; i++) wr(5'(i), pat(i));
        for (int unsigned i = 0; i < 32; i++) begin
            a2 = (i * 7) % 32;
            A1 = 5'(i); A2 = 5'(a2);
            expect_rd("pattern_readback", pat(i), pat(a2));
            step();
        end

        // Drain the scoreboard with a bounded wait
        for (int i = 0; i < 10 && exp_q.size() > 0; i++) step();
        if (exp_q.size() > 0) begin
            mismatched++;
            $display("FAIL scoreboard_drain: %0d pending expected 0", exp_q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
